// File: rtl/vit_fixed_pkg.sv
// Fixed-point helpers shared by the ViT encoder datapath: accumulator sizing,
// binary-point realignment and saturation on a wide signed working type.
package vit_fixed_pkg;

    localparam int FIX_MAX_W = 128;
    typedef logic signed [FIX_MAX_W-1:0] fix_wide_t;

    // Two guard bits: one for the add carry, one spare so saturation sees the true sign.
    function automatic int sum_width(input int in_w, input int in_frac,
                                     input int mlp_w, input int mlp_frac,
                                     input int out_frac);
        int in_int;
        int mlp_int;
        in_int  = in_w - in_frac;
        mlp_int = mlp_w - mlp_frac;
        return ((in_int > mlp_int) ? in_int : mlp_int) + 2 + out_frac;
    endfunction

    function automatic fix_wide_t fixed_align(input fix_wide_t value,
                                              input int from_frac,
                                              input int to_frac);
        if (from_frac < to_frac)
            return value <<< (to_frac - from_frac);
        else
            return value >>> (from_frac - to_frac);
    endfunction

    function automatic fix_wide_t fixed_sat(input fix_wide_t value, input int out_width);
        fix_wide_t hi;
        fix_wide_t lo;
        hi = (fix_wide_t'(1) <<< (out_width - 1)) - fix_wide_t'(1);
        lo = -(fix_wide_t'(1) <<< (out_width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage

// File: rtl/skip_block_fifo.sv
// Skip-path block FIFO: holds one input block per entry until its MLP result
// returns. Head entry is presented from a registered read of the block RAM.
module skip_block_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + CW'(1);
        else if (!do_push && do_pop)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // A write landing on the next head slot means the FIFO was otherwise
    // empty there, so forward it straight into the head register.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
        if (do_push && (wr_ptr_reg == rd_ptr_next))
            head_reg <= push_data;
        else
            head_reg <= mem[rd_ptr_next];
    end

    assign head_data = head_reg;
    assign count     = count_reg;

endmodule

// File: rtl/fixed_residual_fork_add.sv
// Residual stage around the MLP: forks each block to the MLP while buffering a
// copy, then adds the returning MLP block to the copy with realign + saturate.
module fixed_residual_fork_add
    import vit_fixed_pkg::*;
#(
    parameter int IN_WIDTH       = 32,
    parameter int IN_FRAC_WIDTH  = 8,
    parameter int MLP_WIDTH      = 32,
    parameter int MLP_FRAC_WIDTH = 8,
    parameter int OUT_WIDTH      = 32,
    parameter int OUT_FRAC_WIDTH = 8,
    parameter int BLOCK_SIZE     = 8,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BLOCK_SIZE*IN_WIDTH-1:0]  data_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic [BLOCK_SIZE*IN_WIDTH-1:0]  fork_out,
    output logic                            fork_out_valid,
    input  logic                            fork_out_ready,
    input  logic [BLOCK_SIZE*MLP_WIDTH-1:0] mlp_in,
    input  logic                            mlp_in_valid,
    output logic                            mlp_in_ready,
    output logic [BLOCK_SIZE*OUT_WIDTH-1:0] data_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     skip_count
);

    localparam int SUM_W = sum_width(IN_WIDTH, IN_FRAC_WIDTH, MLP_WIDTH,
                                     MLP_FRAC_WIDTH, OUT_FRAC_WIDTH);

    logic                            full;
    logic                            empty;
    logic                            push;
    logic                            load;
    logic [BLOCK_SIZE*IN_WIDTH-1:0]  skip_head;
    logic [BLOCK_SIZE*OUT_WIDTH-1:0] sum_next;
    logic [BLOCK_SIZE*OUT_WIDTH-1:0] data_out_reg;
    logic                            data_out_valid_reg;

    // MLP and skip FIFO accept the block in the same cycle or not at all.
    assign fork_out       = data_in;
    assign fork_out_valid = data_in_valid & ~full;
    assign data_in_ready  = fork_out_ready & ~full;
    assign push           = data_in_valid & data_in_ready;

    assign mlp_in_ready = ~empty & (~data_out_valid_reg | data_out_ready);
    assign load         = mlp_in_valid & mlp_in_ready;

    skip_block_fifo #(
        .WIDTH (BLOCK_SIZE*IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_skip_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_in),
        .pop       (load),
        .head_data (skip_head),
        .full      (full),
        .empty     (empty),
        .count     (skip_count)
    );

    generate
        for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_lane
            fix_wide_t               skip_al;
            fix_wide_t               mlp_al;
            fix_wide_t               sum_sat;
            logic signed [SUM_W-1:0] skip_s;
            logic signed [SUM_W-1:0] mlp_s;
            logic signed [SUM_W-1:0] sum_s;
            logic                    lane_unused;

            assign skip_al = fixed_align(fix_wide_t'($signed(skip_head[gi*IN_WIDTH +: IN_WIDTH])),
                                         IN_FRAC_WIDTH, OUT_FRAC_WIDTH);
            assign mlp_al  = fixed_align(fix_wide_t'($signed(mlp_in[gi*MLP_WIDTH +: MLP_WIDTH])),
                                         MLP_FRAC_WIDTH, OUT_FRAC_WIDTH);
            assign skip_s  = skip_al[SUM_W-1:0];
            assign mlp_s   = mlp_al[SUM_W-1:0];
            assign sum_s   = skip_s + mlp_s;
            assign sum_sat = fixed_sat(fix_wide_t'(sum_s), OUT_WIDTH);
            assign sum_next[gi*OUT_WIDTH +: OUT_WIDTH] = sum_sat[OUT_WIDTH-1:0];

            // Upper bits are sign copies once the value fits SUM_W / OUT_WIDTH.
            assign lane_unused = ^{skip_al[FIX_MAX_W-1:SUM_W], mlp_al[FIX_MAX_W-1:SUM_W],
                                   sum_sat[FIX_MAX_W-1:OUT_WIDTH]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_reg       <= '0;
            data_out_valid_reg <= 1'b0;
        end else if (load) begin
            data_out_reg       <= sum_next;
            data_out_valid_reg <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid_reg <= 1'b0;
        end
    end

    assign data_out       = data_out_reg;
    assign data_out_valid = data_out_valid_reg;

endmodule

// File: tb/tb_fixed_residual_fork_add.sv
// Directed bench for the residual fork/add stage: default instance plus a
// coarse-MLP / 16-bit-output instance for alignment and saturation.
module tb_fixed_residual_fork_add;

    localparam int BS  = 8;
    localparam int W   = 32;
    localparam int OWB = 16;
    localparam int NRAND = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [BS*W-1:0] a_data_in, a_fork_out, a_mlp_in, a_data_out;
    logic a_data_in_valid, a_data_in_ready, a_fork_out_valid, a_fork_out_ready;
    logic a_mlp_in_valid, a_mlp_in_ready, a_data_out_valid, a_data_out_ready;
    logic [4:0] a_skip_count;

    logic [BS*W-1:0]   b_data_in, b_fork_out, b_mlp_in;
    logic [BS*OWB-1:0] b_data_out;
    logic b_data_in_valid, b_data_in_ready, b_fork_out_valid, b_fork_out_ready;
    logic b_mlp_in_valid, b_mlp_in_ready, b_data_out_valid, b_data_out_ready;
    logic [4:0] b_skip_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] b_skip_v [BS] = '{32'h100, 32'h7F00, 32'hFFFF8000, 32'h7EFF,
                                   32'hFFFF8100, 32'h0, 32'hFFFFFF80, 32'h12345};
    logic [31:0] b_mlp_v  [BS] = '{32'h18, 32'h20, 32'hFFFFFFF0, 32'h10,
                                   32'hFFFFFFF0, 32'h0, 32'h8, 32'h0};
    logic [15:0] b_exp_v  [BS] = '{16'h280, 16'h7FFF, 16'h8000, 16'h7FFF,
                                   16'h8000, 16'h0, 16'h0, 16'h7FFF};

    fixed_residual_fork_add u_dut_a (
        .clk(clk), .rst(rst),
        .data_in(a_data_in), .data_in_valid(a_data_in_valid), .data_in_ready(a_data_in_ready),
        .fork_out(a_fork_out), .fork_out_valid(a_fork_out_valid), .fork_out_ready(a_fork_out_ready),
        .mlp_in(a_mlp_in), .mlp_in_valid(a_mlp_in_valid), .mlp_in_ready(a_mlp_in_ready),
        .data_out(a_data_out), .data_out_valid(a_data_out_valid), .data_out_ready(a_data_out_ready),
        .skip_count(a_skip_count)
    );

    fixed_residual_fork_add #(.MLP_FRAC_WIDTH(4), .OUT_WIDTH(OWB)) u_dut_b (
        .clk(clk), .rst(rst),
        .data_in(b_data_in), .data_in_valid(b_data_in_valid), .data_in_ready(b_data_in_ready),
        .fork_out(b_fork_out), .fork_out_valid(b_fork_out_valid), .fork_out_ready(b_fork_out_ready),
        .mlp_in(b_mlp_in), .mlp_in_valid(b_mlp_in_valid), .mlp_in_ready(b_mlp_in_ready),
        .data_out(b_data_out), .data_out_valid(b_data_out_valid), .data_out_ready(b_data_out_ready),
        .skip_count(b_skip_count)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BS*W-1:0] fill_blk(input logic [31:0] base, input logic [31:0] step);
        logic [BS*W-1:0] r;
        for (int e = 0; e < BS; e++)
            r[e*W +: W] = base + step * 32'(e);
        return r;
    endfunction

    function automatic logic [BS*W-1:0] mlp_blk(input int k);
        return fill_blk(-32'(k), 32'd16);
    endfunction

    // Skip block k holds k*256+e, MLP block k holds 16e-k.
    function automatic logic [BS*W-1:0] exp_blk(input int k);
        return fill_blk(32'(k*256 - k), 32'd17);
    endfunction

    function automatic logic [BS*W-1:0] rand_blk();
        logic [BS*W-1:0] r;
        for (int e = 0; e < BS; e++)
            r[e*W +: W] = 32'($urandom_range(0, 1048575)) - 32'd524288;
        return r;
    endfunction

    function automatic logic [BS*W-1:0] add_blk(input logic [BS*W-1:0] x, input logic [BS*W-1:0] y);
        logic [BS*W-1:0] r;
        for (int e = 0; e < BS; e++)
            r[e*W +: W] = x[e*W +: W] + y[e*W +: W];
        return r;
    endfunction

    initial begin
        logic [BS*W-1:0] skip_q [$];
        logic [BS*W-1:0] exp_q  [$];
        logic [BS*W-1:0] cur_in;
        logic [BS*W-1:0] exp_front;
        logic fire_in, fire_mlp, fire_out;
        int sent, mret, outs;

        rst = 1'b0;
        a_data_in = '0; a_data_in_valid = 0; a_fork_out_ready = 1;
        a_mlp_in = '0; a_mlp_in_valid = 0; a_data_out_ready = 1;
        b_data_in = '0; b_data_in_valid = 0; b_fork_out_ready = 1;
        b_mlp_in = '0; b_mlp_in_valid = 0; b_data_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_skip_count", a_skip_count, 0);
        check("rst_out_valid", a_data_out_valid, 0);
        check("rst_data_out", a_data_out, 0);
        check("rst_mlp_ready", a_mlp_in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single block: 1.5 + 0.25 = 1.75
        a_data_in = fill_blk(32'h180, 32'h1);
        a_data_in_valid = 1;
        #1;
        check("fork_valid", a_fork_out_valid, 1);
        check("fork_data", a_fork_out, fill_blk(32'h180, 32'h1));
        check("in_ready", a_data_in_ready, 1);
        @(posedge clk); #1;
        a_data_in_valid = 0;
        check("count_after_push", a_skip_count, 1);
        check("mlp_ready_nonempty", a_mlp_in_ready, 1);
        a_mlp_in = fill_blk(32'h40, 32'h0);
        a_mlp_in_valid = 1;
        @(posedge clk); #1;
        a_mlp_in_valid = 0;
        check("single_valid", a_data_out_valid, 1);
        check("single_data", a_data_out, fill_blk(32'h1C0, 32'h1));
        check("count_after_pop", a_skip_count, 0);
        $display("single block out=%h", a_data_out[31:0]);
        @(posedge clk); #1;
        check("valid_clears", a_data_out_valid, 0);

        // Fill the skip FIFO with no MLP results returning
        for (int k = 1; k <= 16; k++) begin
            a_data_in = fill_blk(32'(k << 8), 32'h1);
            a_data_in_valid = 1;
            @(posedge clk); #1;
        end
        a_data_in = fill_blk(32'h1100, 32'h1);
        check("full_count", a_skip_count, 16);
        check("full_in_ready", a_data_in_ready, 0);
        check("full_fork_valid", a_fork_out_valid, 0);
        @(posedge clk); #1;
        check("full_no_push", a_skip_count, 16);
        a_data_in_valid = 0;

        // Downstream stall with results pending
        a_data_out_ready = 0;
        a_mlp_in = mlp_blk(1);
        a_mlp_in_valid = 1;
        @(posedge clk); #1;
        a_mlp_in = mlp_blk(2);
        check("stall_first_valid", a_data_out_valid, 1);
        check("stall_first_data", a_data_out, exp_blk(1));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_hold", a_data_out, exp_blk(1));
            check("stall_mlp_ready", a_mlp_in_ready, 0);
            check("stall_count", a_skip_count, 15);
        end

        // Drain in push order at one block per cycle
        a_data_out_ready = 1;
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("drain_valid_%0d", k), a_data_out_valid, 1);
            check($sformatf("drain_data_%0d", k), a_data_out, exp_blk(k));
            $display("drain block %0d out=%h", k, a_data_out[31:0]);
            @(posedge clk); #1;
            if (k + 2 <= 16)
                a_mlp_in = mlp_blk(k + 2);
            else
                a_mlp_in_valid = 0;
        end
        check("drain_end_valid", a_data_out_valid, 0);
        check("drain_end_count", a_skip_count, 0);
        check("drain_end_mlp_ready", a_mlp_in_ready, 0);

        // Reset mid-stream with 6 blocks buffered and one result held
        a_data_out_ready = 0;
        for (int k = 1; k <= 7; k++) begin
            a_data_in = fill_blk(32'(k << 12), 32'h1);
            a_data_in_valid = 1;
            @(posedge clk); #1;
        end
        a_data_in_valid = 0;
        a_mlp_in = mlp_blk(1);
        a_mlp_in_valid = 1;
        @(posedge clk); #1;
        a_mlp_in_valid = 0;
        check("pre_rst_count", a_skip_count, 6);
        check("pre_rst_valid", a_data_out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_count", a_skip_count, 0);
        check("mid_rst_valid", a_data_out_valid, 0);
        check("mid_rst_data", a_data_out, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        a_mlp_in_valid = 1;
        #1;
        check("post_rst_mlp_ready", a_mlp_in_ready, 0);
        @(posedge clk); #1;
        check("post_rst_no_pop", a_data_out_valid, 0);
        a_data_in = fill_blk(32'h500, 32'h0);
        a_data_in_valid = 1;
        @(posedge clk); #1;
        a_data_in_valid = 0;
        check("post_rst_push_count", a_skip_count, 1);
        check("post_rst_mlp_ready_up", a_mlp_in_ready, 1);
        @(posedge clk); #1;
        a_mlp_in_valid = 0;
        check("post_rst_sum", a_data_out, fill_blk(32'h4FF, 32'd16));
        a_data_out_ready = 1;
        @(posedge clk); #1;

        // Coarse MLP fraction and 16-bit saturating output
        for (int e = 0; e < BS; e++) begin
            b_data_in[e*W +: W] = b_skip_v[e];
            b_mlp_in[e*W +: W]  = b_mlp_v[e];
        end
        b_data_in_valid = 1;
        @(posedge clk); #1;
        b_data_in_valid = 0;
        b_mlp_in_valid = 1;
        @(posedge clk); #1;
        b_mlp_in_valid = 0;
        check("b_valid", b_data_out_valid, 1);
        for (int e = 0; e < BS; e++)
            check($sformatf("b_elem_%0d", e), b_data_out[e*OWB +: OWB], b_exp_v[e]);
        $display("b block out=%h", b_data_out);

        // Random handshakes against a queue model
        sent = 0; mret = 0; outs = 0;
        cur_in = rand_blk();
        for (int cyc = 0; cyc < 6000 && outs < NRAND; cyc++) begin
            a_data_in = cur_in;
            a_data_in_valid = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            a_mlp_in = fill_blk(32'(mret * 3), 32'hFFFFFFFB);
            a_mlp_in_valid = (mret < sent) && ($urandom_range(0, 2) != 0);
            a_data_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            fire_in  = a_data_in_valid & a_data_in_ready;
            fire_mlp = a_mlp_in_valid & a_mlp_in_ready;
            fire_out = a_data_out_valid & a_data_out_ready;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_out", a_data_out_valid, 0);
                end else begin
                    exp_front = exp_q.pop_front();
                    check($sformatf("rand_out_%0d", outs), a_data_out, exp_front);
                    $display("rand block %0d out=%h", outs, a_data_out[31:0]);
                end
                outs++;
            end
            @(posedge clk); #1;
            if (fire_in) begin
                skip_q.push_back(cur_in);
                sent++;
                cur_in = rand_blk();
            end
            if (fire_mlp && skip_q.size() > 0) begin
                exp_q.push_back(add_blk(skip_q.pop_front(), fill_blk(32'(mret * 3), 32'hFFFFFFFB)));
                mret++;
            end
            check("rand_count", a_skip_count, skip_q.size());
        end
        check("rand_done", outs, NRAND);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
